// File: rtl/endian_swapper_pkg.sv
// Shared constants and the width-agnostic byte-group swap for endian_swapper_gen.
`default_nettype none

package endian_swapper_pkg;

  localparam logic [1:0] CSR_CTRL     = 2'd0;
  localparam logic [1:0] CSR_PKT_CNT  = 2'd1;
  localparam logic [1:0] CSR_BYTE_CNT = 2'd2;
  localparam logic [1:0] CSR_STATUS   = 2'd3;

  localparam int STAT_IN_PACKET = 0;
  localparam int STAT_PROTO_ERR = 1;
  localparam int STAT_BUSY      = 2;

  localparam int MAX_BYTES = 64;

  typedef logic [MAX_BYTES*8-1:0] bus_max_t;

  // Reverses bytes inside each 2**mode-byte group of the low nbytes bytes.
  // Callers keep mode <= log2(nbytes), so the source index stays in range.
  function automatic bus_max_t swap_bytes(input bus_max_t data,
                                          input int unsigned nbytes,
                                          input int unsigned mode);
    bus_max_t    res;
    int unsigned grp;
    int unsigned src;
    res = '0;
    grp = 32'd1 << mode;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i < nbytes) begin
        src = (i & ~(grp - 1)) + (grp - 1) - (i & (grp - 1));
        res[8*i +: 8] = data[8*src +: 8];
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/endian_swapper_gen_skid.sv
// Generic two-register ready/valid buffer: output register plus one skid slot.
`default_nettype none

module stream_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_payload,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] skid_q;
  logic             out_v;
  logic             skid_v;
  logic             rdy_q;
  logic             accept;
  logic             out_free;
  logic             skid_next;

  assign accept   = in_valid && rdy_q;
  assign out_free = !out_v || out_ready;
  // The skid slot only fills while the output register is stalled.
  assign skid_next = out_free ? 1'b0 : (skid_v || accept);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_v) begin
          out_q  <= skid_q;
          out_v  <= 1'b1;
          skid_v <= 1'b0;
        end else if (accept) begin
          out_q <= in_payload;
          out_v <= 1'b1;
        end else begin
          out_v <= 1'b0;
        end
      end else if (accept) begin
        skid_q <= in_payload;
        skid_v <= 1'b1;
      end
      rdy_q <= !skid_next;
    end
  end

  assign in_ready    = rdy_q;
  assign out_payload = out_q;
  assign out_valid   = out_v;
  assign busy        = out_v || skid_v;

endmodule

`default_nettype wire

// File: rtl/endian_swapper_gen.sv
// Avalon-ST endian swapper with CSR-selectable group size, skid-buffered output
// and an Avalon-MM status/counter slave.
`default_nettype none

module endian_swapper_gen
  import endian_swapper_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int MODE_W     = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BYTES*8-1:0]       stream_in_data,
  input  logic [$clog2(DATA_BYTES)-1:0] stream_in_empty,
  input  logic                          stream_in_valid,
  input  logic                          stream_in_startofpacket,
  input  logic                          stream_in_endofpacket,
  output logic                          stream_in_ready,
  output logic [DATA_BYTES*8-1:0]       stream_out_data,
  output logic [$clog2(DATA_BYTES)-1:0] stream_out_empty,
  output logic                          stream_out_valid,
  output logic                          stream_out_startofpacket,
  output logic                          stream_out_endofpacket,
  input  logic                          stream_out_ready,
  input  logic [1:0]                    csr_address,
  input  logic                          csr_read,
  input  logic                          csr_write,
  input  logic [31:0]                   csr_writedata,
  output logic [31:0]                   csr_readdata,
  output logic                          csr_readdatavalid,
  output logic                          csr_waitrequest
);

  localparam int DATA_W    = DATA_BYTES * 8;
  localparam int EMPTY_W   = $clog2(DATA_BYTES);
  localparam int PAYLOAD_W = DATA_W + EMPTY_W + 2;
  localparam int MAX_MODE  = $clog2(DATA_BYTES);

  logic [MODE_W-1:0]    mode;
  logic [31:0]          pkt_cnt;
  logic [31:0]          byte_cnt;
  logic                 in_packet;
  logic                 proto_err;
  logic                 busy;
  logic                 accept;
  logic                 sop_acc;
  logic                 eop_acc;
  logic                 err_event;
  logic                 ctrl_wr;
  logic                 pkt_clr;
  logic                 byte_clr;
  logic                 err_w1c;
  logic [31:0]          byte_inc;
  logic [31:0]          rd_mux;
  bus_max_t             swap_in;
  logic [DATA_W-1:0]    swapped;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;

  always_comb begin
    swap_in               = '0;
    swap_in[DATA_W-1:0]   = stream_in_data;
    swapped = DATA_W'(swap_bytes(swap_in, DATA_BYTES, 32'(mode)));
  end

  assign in_payload = {swapped, stream_in_empty,
                       stream_in_startofpacket, stream_in_endofpacket};

  stream_skid_buffer #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_payload  (in_payload),
    .in_valid    (stream_in_valid),
    .in_ready    (stream_in_ready),
    .out_payload (out_payload),
    .out_valid   (stream_out_valid),
    .out_ready   (stream_out_ready),
    .busy        (busy)
  );

  assign {stream_out_data, stream_out_empty,
          stream_out_startofpacket, stream_out_endofpacket} = out_payload;

  assign accept    = stream_in_valid && stream_in_ready;
  assign sop_acc   = accept && stream_in_startofpacket;
  assign eop_acc   = accept && stream_in_endofpacket;
  assign err_event = accept && (stream_in_startofpacket ? in_packet : !in_packet);
  assign byte_inc  = 32'(DATA_BYTES)
                   - (stream_in_endofpacket ? 32'(stream_in_empty) : 32'd0);

  // Mode writes stall until the stream is between packets and fully drained.
  assign csr_waitrequest = reset ||
                           (csr_write && (csr_address == CSR_CTRL) &&
                            (in_packet || busy || sop_acc));

  assign ctrl_wr  = csr_write && !csr_waitrequest && (csr_address == CSR_CTRL);
  assign pkt_clr  = csr_write && (csr_address == CSR_PKT_CNT);
  assign byte_clr = csr_write && (csr_address == CSR_BYTE_CNT);
  assign err_w1c  = csr_write && (csr_address == CSR_STATUS) && csr_writedata[STAT_PROTO_ERR];

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      CSR_CTRL:     rd_mux[MODE_W-1:0] = mode;
      CSR_PKT_CNT:  rd_mux = pkt_cnt;
      CSR_BYTE_CNT: rd_mux = byte_cnt;
      default: begin
        rd_mux[STAT_IN_PACKET] = in_packet;
        rd_mux[STAT_PROTO_ERR] = proto_err;
        rd_mux[STAT_BUSY]      = busy;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode              <= '0;
      pkt_cnt           <= '0;
      byte_cnt          <= '0;
      in_packet         <= 1'b0;
      proto_err         <= 1'b0;
      csr_readdata      <= '0;
      csr_readdatavalid <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        if (csr_writedata > 32'(MAX_MODE)) begin
          mode <= MODE_W'(MAX_MODE);
        end else begin
          mode <= csr_writedata[MODE_W-1:0];
        end
      end

      if (pkt_clr) begin
        pkt_cnt <= sop_acc ? 32'd1 : 32'd0;
      end else if (sop_acc) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end

      if (byte_clr) begin
        byte_cnt <= accept ? byte_inc : 32'd0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + byte_inc;
      end

      if (accept) begin
        if (stream_in_endofpacket) begin
          in_packet <= 1'b0;
        end else if (stream_in_startofpacket) begin
          in_packet <= 1'b1;
        end
      end

      // A fresh error wins over a simultaneous clear.
      if (err_event) begin
        proto_err <= 1'b1;
      end else if (err_w1c) begin
        proto_err <= 1'b0;
      end

      csr_readdatavalid <= csr_read;
      if (csr_read) begin
        csr_readdata <= rd_mux;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_endian_swapper_gen.sv
// Directed self-checking bench for endian_swapper_gen at DATA_BYTES=8.
`default_nettype none

module tb_endian_swapper_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] stream_in_data;
  logic [2:0]  stream_in_empty;
  logic        stream_in_valid;
  logic        stream_in_startofpacket;
  logic        stream_in_endofpacket;
  logic        stream_in_ready;
  logic [63:0] stream_out_data;
  logic [2:0]  stream_out_empty;
  logic        stream_out_valid;
  logic        stream_out_startofpacket;
  logic        stream_out_endofpacket;
  logic        stream_out_ready;
  logic [1:0]  csr_address;
  logic        csr_read;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;
  logic        csr_readdatavalid;
  logic        csr_waitrequest;

  int vectors    = 0;
  int miscompares = 0;
  logic [63:0] cap_q[$];

  localparam logic [63:0] PATTERN = 64'h0001020304050607;

  endian_swapper_gen #(.DATA_BYTES(8), .MODE_W(3)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .stream_in_data           (stream_in_data),
    .stream_in_empty          (stream_in_empty),
    .stream_in_valid          (stream_in_valid),
    .stream_in_startofpacket  (stream_in_startofpacket),
    .stream_in_endofpacket    (stream_in_endofpacket),
    .stream_in_ready          (stream_in_ready),
    .stream_out_data          (stream_out_data),
    .stream_out_empty         (stream_out_empty),
    .stream_out_valid         (stream_out_valid),
    .stream_out_startofpacket (stream_out_startofpacket),
    .stream_out_endofpacket   (stream_out_endofpacket),
    .stream_out_ready         (stream_out_ready),
    .csr_address              (csr_address),
    .csr_read                 (csr_read),
    .csr_write                (csr_write),
    .csr_writedata            (csr_writedata),
    .csr_readdata             (csr_readdata),
    .csr_readdatavalid        (csr_readdatavalid),
    .csr_waitrequest          (csr_waitrequest)
  );

  always #5 clk = ~clk;

  // Inputs only change 1ns after posedge, so the negedge sees the handshake.
  always @(negedge clk) begin
    if (stream_out_valid && stream_out_ready) cap_q.push_back(stream_out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [2:0] e,
                           input logic s, input logic eo);
    bit done = 1'b0;
    stream_in_data          = d;
    stream_in_empty         = e;
    stream_in_startofpacket = s;
    stream_in_endofpacket   = eo;
    stream_in_valid         = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      if (stream_in_ready) done = 1'b1;
      tick();
    end
    stream_in_valid         = 1'b0;
    stream_in_startofpacket = 1'b0;
    stream_in_endofpacket   = 1'b0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL send_beat: stream_in_ready stayed 0, required 1");
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    bit done = 1'b0;
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      #1;
      if (!csr_waitrequest) done = 1'b1;
      tick();
    end
    csr_write = 1'b0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL csr_wr addr %0d: waitrequest stayed 1, required 0", a);
    end
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d, output logic v);
    csr_address = a;
    csr_read    = 1'b1;
    tick();
    csr_read = 1'b0;
    d = csr_readdata;
    v = csr_readdatavalid;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        v;
    reset = 1'b1;
    repeat (3) tick();
    vectors++;
    if (stream_out_valid !== 1'b0 || stream_out_data !== 64'h0 || stream_out_empty !== 3'h0 ||
        stream_out_startofpacket !== 1'b0 || stream_out_endofpacket !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b data=%h empty=%h sop=%b eop=%b, required all 0",
               stream_out_valid, stream_out_data, stream_out_empty,
               stream_out_startofpacket, stream_out_endofpacket);
    end
    vectors++;
    if (stream_in_ready !== 1'b0 || csr_waitrequest !== 1'b1 ||
        csr_readdatavalid !== 1'b0 || csr_readdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl: in_ready=%b waitreq=%b rdv=%b rd=%h, required 0/1/0/0",
               stream_in_ready, csr_waitrequest, csr_readdatavalid, csr_readdata);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (stream_in_ready !== 1'b1 || stream_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0",
               stream_in_ready, stream_out_valid);
    end
    for (int a = 0; a < 4; a++) begin
      csr_rd(2'(a), d, v);
      vectors++;
      if (v !== 1'b1 || d !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_csr%0d: rdv=%b data=%h, required 1/00000000", a, v, d);
      end
    end
    tick();
    vectors++;
    if (csr_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rdv_pulse: rdv=%b, required 0", csr_readdatavalid);
    end
  endtask

  task automatic test_modes();
    logic [31:0] modes [4];
    logic [63:0] exps  [4];
    logic [31:0] d;
    logic        v;
    modes = '{32'd3, 32'd1, 32'd2, 32'd0};
    exps  = '{64'h0706050403020100, 64'h0100030205040706,
              64'h0302010007060504, 64'h0001020304050607};
    stream_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      csr_wr(2'd0, modes[k]);
      send_beat(PATTERN, 3'd5, 1'b1, 1'b1);
      vectors++;
      if (stream_out_valid !== 1'b1 || stream_out_data !== exps[k] ||
          stream_out_empty !== 3'd5 || stream_out_startofpacket !== 1'b1 ||
          stream_out_endofpacket !== 1'b1) begin
        miscompares++;
        $display("FAIL mode%0d: valid=%b data=%h empty=%0d sop=%b eop=%b, required 1 %h 5 1 1",
                 modes[k], stream_out_valid, stream_out_data, stream_out_empty,
                 stream_out_startofpacket, stream_out_endofpacket, exps[k]);
      end
      tick();
    end
    csr_wr(2'd0, 32'd7);
    csr_rd(2'd0, d, v);
    vectors++;
    if (v !== 1'b1 || d !== 32'd3) begin
      miscompares++;
      $display("FAIL mode_saturate: read %h, required 00000003", d);
    end
    csr_wr(2'd0, 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] beats [4];
    logic        pat   [8];
    int          k = 0;
    logic        rdy_now;
    beats = '{64'h1111111111111111, 64'h2222222222222222,
              64'h3333333333333333, 64'h4444444444444444};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    cap_q.delete();
    for (int c = 0; c < 10; c++) begin
      stream_out_ready = (c < 8) ? pat[c] : 1'b1;
      if (k < 4) begin
        stream_in_data          = beats[k];
        stream_in_empty         = 3'd0;
        stream_in_startofpacket = (k == 0);
        stream_in_endofpacket   = (k == 3);
        stream_in_valid         = 1'b1;
      end else begin
        stream_in_valid = 1'b0;
      end
      rdy_now = stream_in_ready;
      if (c == 2) begin
        vectors++;
        if (stream_in_ready !== 1'b0 || stream_out_valid !== 1'b1 || stream_out_data !== beats[0]) begin
          miscompares++;
          $display("FAIL skid_full: in_ready=%b out_valid=%b data=%h, required 0 1 %h",
                   stream_in_ready, stream_out_valid, stream_out_data, beats[0]);
        end
      end
      if (c >= 3 && c <= 6) begin
        vectors++;
        if (stream_out_valid !== 1'b1 || stream_out_data !== beats[c-3]) begin
          miscompares++;
          $display("FAIL no_gap c%0d: valid=%b data=%h, required 1 %h",
                   c, stream_out_valid, stream_out_data, beats[c-3]);
        end
      end
      tick();
      if (stream_in_valid && rdy_now) k++;
    end
    stream_in_valid = 1'b0;
    stream_in_startofpacket = 1'b0;
    stream_in_endofpacket = 1'b0;
    vectors++;
    if (cap_q.size() != 4) begin
      miscompares++;
      $display("FAIL bp_count: got %0d beats, required 4", cap_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (cap_q[i] !== beats[i]) begin
          miscompares++;
          $display("FAIL bp_order beat%0d: got %h, required %h", i, cap_q[i], beats[i]);
        end
      end
    end
  endtask

  task automatic test_counters();
    logic [31:0] d;
    logic        v;
    stream_out_ready = 1'b1;
    csr_wr(2'd1, 32'h0);
    csr_wr(2'd2, 32'h0);
    for (int p = 0; p < 3; p++) begin
      send_beat(64'hA0 + 64'(p), 3'd0, 1'b1, 1'b0);
      send_beat(64'hB0 + 64'(p), 3'd3, 1'b0, 1'b1);
    end
    csr_rd(2'd1, d, v);
    vectors++;
    if (d !== 32'd3) begin
      miscompares++;
      $display("FAIL pkt_count: read %0d, required 3", d);
    end
    csr_rd(2'd2, d, v);
    vectors++;
    if (d !== 32'd39) begin
      miscompares++;
      $display("FAIL byte_count: read %0d, required 39", d);
    end
    // Clear the packet counter in the very cycle an SOP is accepted.
    csr_address             = 2'd1;
    csr_writedata           = 32'h0;
    csr_write               = 1'b1;
    stream_in_data          = 64'hC0;
    stream_in_empty         = 3'd0;
    stream_in_startofpacket = 1'b1;
    stream_in_endofpacket   = 1'b1;
    stream_in_valid         = 1'b1;
    #1;
    vectors++;
    if (csr_waitrequest !== 1'b0 || stream_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_setup: waitreq=%b in_ready=%b, required 0/1", csr_waitrequest, stream_in_ready);
    end
    tick();
    csr_write = 1'b0;
    stream_in_valid = 1'b0;
    stream_in_startofpacket = 1'b0;
    stream_in_endofpacket = 1'b0;
    csr_rd(2'd1, d, v);
    vectors++;
    if (d !== 32'd1) begin
      miscompares++;
      $display("FAIL clr_and_inc: read %0d, required 1", d);
    end
    csr_rd(2'd2, d, v);
    vectors++;
    if (d !== 32'd47) begin
      miscompares++;
      $display("FAIL byte_count2: read %0d, required 47", d);
    end
  endtask

  task automatic test_midpacket_mode();
    logic [31:0] d;
    logic        v;
    stream_out_ready = 1'b1;
    cap_q.delete();
    send_beat(PATTERN, 3'd0, 1'b1, 1'b0);
    csr_address   = 2'd0;
    csr_writedata = 32'd2;
    csr_write     = 1'b1;
    #1;
    vectors++;
    if (csr_waitrequest !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_stall_busy: waitreq=%b, required 1", csr_waitrequest);
    end
    tick();
    vectors++;
    if (csr_waitrequest !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_stall_inpkt: waitreq=%b, required 1", csr_waitrequest);
    end
    stream_in_data        = PATTERN;
    stream_in_empty       = 3'd0;
    stream_in_endofpacket = 1'b1;
    stream_in_valid       = 1'b1;
    tick();
    stream_in_valid       = 1'b0;
    stream_in_endofpacket = 1'b0;
    #1;
    vectors++;
    if (csr_waitrequest !== 1'b1 || stream_out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_stall_drain: waitreq=%b out_valid=%b, required 1/1",
               csr_waitrequest, stream_out_valid);
    end
    tick();
    vectors++;
    if (csr_waitrequest !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_release: waitreq=%b, required 0", csr_waitrequest);
    end
    tick();
    csr_write = 1'b0;
    vectors++;
    if (cap_q.size() != 2 || cap_q[0] !== PATTERN || cap_q[1] !== PATTERN) begin
      miscompares++;
      $display("FAIL midpkt_unchanged: %0d beats, required 2 beats of %h", cap_q.size(), PATTERN);
    end
    csr_rd(2'd0, d, v);
    vectors++;
    if (d !== 32'd2) begin
      miscompares++;
      $display("FAIL mode_after: read %0d, required 2", d);
    end
    send_beat(PATTERN, 3'd0, 1'b1, 1'b1);
    vectors++;
    if (stream_out_data !== 64'h0302010007060504) begin
      miscompares++;
      $display("FAIL next_pkt_mode2: got %h, required 0302010007060504", stream_out_data);
    end
    tick();
  endtask

  task automatic test_protocol_error();
    logic [31:0] d;
    logic        v;
    stream_out_ready = 1'b1;
    csr_wr(2'd0, 32'd0);
    cap_q.delete();
    send_beat(64'hAAAA, 3'd0, 1'b1, 1'b0);
    tick();
    csr_rd(2'd3, d, v);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL status_inpkt: read %h, required 00000001", d);
    end
    send_beat(64'hBBBB, 3'd0, 1'b1, 1'b0);
    send_beat(64'hCCCC, 3'd0, 1'b0, 1'b1);
    tick();
    tick();
    csr_rd(2'd3, d, v);
    vectors++;
    if (d !== 32'h2) begin
      miscompares++;
      $display("FAIL status_err: read %h, required 00000002", d);
    end
    vectors++;
    if (cap_q.size() != 3 || cap_q[0] !== 64'hAAAA || cap_q[1] !== 64'hBBBB || cap_q[2] !== 64'hCCCC) begin
      miscompares++;
      $display("FAIL err_forward: %0d beats, required AAAA BBBB CCCC", cap_q.size());
    end
    csr_wr(2'd3, 32'h2);
    csr_rd(2'd3, d, v);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL err_w1c: read %h, required 00000000", d);
    end
    // Stray non-SOP beat lands in the same cycle as the clear.
    csr_address             = 2'd3;
    csr_writedata           = 32'h2;
    csr_write               = 1'b1;
    stream_in_data          = 64'hDDDD;
    stream_in_empty         = 3'd0;
    stream_in_startofpacket = 1'b0;
    stream_in_endofpacket   = 1'b1;
    stream_in_valid         = 1'b1;
    tick();
    csr_write = 1'b0;
    stream_in_valid = 1'b0;
    stream_in_endofpacket = 1'b0;
    tick();
    csr_rd(2'd3, d, v);
    vectors++;
    if (d[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL err_beats_w1c: bit1=%b, required 1", d[1]);
    end
    csr_wr(2'd3, 32'h2);
  endtask

  task automatic test_reset_midpacket();
    logic [31:0] d;
    logic        v;
    stream_out_ready = 1'b1;
    csr_wr(2'd0, 32'd1);
    stream_out_ready = 1'b0;
    cap_q.delete();
    send_beat(64'h1234, 3'd0, 1'b1, 1'b0);
    send_beat(64'h5678, 3'd0, 1'b0, 1'b0);
    vectors++;
    if (stream_in_ready !== 1'b0 || stream_out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL two_buffered: in_ready=%b out_valid=%b, required 0/1", stream_in_ready, stream_out_valid);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (stream_out_valid !== 1'b0 || stream_in_ready !== 1'b0 || csr_waitrequest !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid: out_valid=%b in_ready=%b waitreq=%b, required 0/0/1",
               stream_out_valid, stream_in_ready, csr_waitrequest);
    end
    reset = 1'b0;
    tick();
    stream_out_ready = 1'b1;
    vectors++;
    if (stream_in_ready !== 1'b1 || stream_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_release: in_ready=%b out_valid=%b, required 1/0", stream_in_ready, stream_out_valid);
    end
    repeat (3) tick();
    vectors++;
    if (cap_q.size() != 0) begin
      miscompares++;
      $display("FAIL rst_no_emit: %0d beats emitted, required 0", cap_q.size());
    end
    for (int a = 0; a < 4; a++) begin
      csr_rd(2'(a), d, v);
      vectors++;
      if (d !== 32'h0) begin
        miscompares++;
        $display("FAIL rst_mid_csr%0d: read %h, required 00000000", a, d);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    stream_in_data = '0;
    stream_in_empty = '0;
    stream_in_valid = 1'b0;
    stream_in_startofpacket = 1'b0;
    stream_in_endofpacket = 1'b0;
    stream_out_ready = 1'b1;
    csr_address = '0;
    csr_read = 1'b0;
    csr_write = 1'b0;
    csr_writedata = '0;
    test_reset();
    test_modes();
    test_back_to_back();
    test_counters();
    test_midpacket_mode();
    test_protocol_error();
    test_reset_midpacket();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/endian_swapper_gen.md
Name: endian_swapper_gen

Overview:
- Parametrised successor to the fixed 64-bit Avalon-ST endian swapper.
- Reverses byte order within a CSR-selectable group size (passthrough, 16, 32, ... up to the full bus width).
- Output is fully registered behind a skid buffer, so throughput is one beat per cycle with true ready/valid backpressure.
- Sits between Avalon-ST packet source and sink; configured and monitored over a 4-register Avalon-MM CSR slave.

Parameters:
- DATA_BYTES, 8, bus width in bytes; power of two, 2..64.
- MODE_W, 3, width of swap-mode field; must satisfy 2**MODE_W > $clog2(DATA_BYTES).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous reset, active-high
- stream_in_data  input  DATA_BYTES*8  sink data
- stream_in_empty  input  $clog2(DATA_BYTES)  empty bytes, valid on EOP beat only
- stream_in_valid / stream_in_startofpacket / stream_in_endofpacket  input  1 each  sink qualifiers
- stream_in_ready  output  1  sink ready, registered
- stream_out_data  output  DATA_BYTES*8  source data
- stream_out_empty  output  $clog2(DATA_BYTES)  source empty
- stream_out_valid / stream_out_startofpacket / stream_out_endofpacket  output  1 each  source qualifiers
- stream_out_ready  input  1  source ready, readyLatency 0
- csr_address  input  2  word address
- csr_read / csr_write  input  1 each  strobes
- csr_writedata  input  32  write data
- csr_readdata  output  32  read data
- csr_readdatavalid  output  1  read data valid, fixed latency 1
- csr_waitrequest  output  1  stall

Behaviour:
- Reset:
  - All valid/readdatavalid/SOP/EOP outputs are 0; data, empty and readdata are 0.
  - stream_in_ready is 0 during reset and 1 on the first cycle after.
  - Mode, counters and error flag are 0.
- Swap:
  - Mode m groups the bus into 2**m-byte groups and reverses bytes within each group.
  - m=0 is passthrough; m=$clog2(DATA_BYTES) is a full reverse.
  - Mode is applied to the whole beat regardless of empty; empty passes through unchanged.
- Datapath:
  - Output register plus one skid register.
  - Input is accepted when stream_in_valid && stream_in_ready.
  - Latency is 1 cycle from acceptance to stream_out_valid.
  - If the output register is held (valid && !ready) when a beat is accepted, the beat goes to the skid register and stream_in_ready drops next cycle.
  - stream_in_ready = !skid_valid (registered).
  - Output data/qualifiers are stable while valid && !ready.
  - Beats are never dropped or duplicated; order is preserved.
- CSR map:
  - Addr 0, RW: [MODE_W-1:0] swap mode; other bits read 0. Writes above $clog2(DATA_BYTES) saturate to $clog2(DATA_BYTES).
  - Addr 1, RW: packet count. Any write clears it.
  - Addr 2, RW: byte count. Any write clears it.
  - Addr 3: bit0 in_packet (RO); bit1 protocol_error (sticky, write-1-to-clear); bit2 pipeline_busy (RO).
- Counters (32-bit, wrap 0xFFFFFFFF->0):
  - Packet count +1 per accepted SOP beat.
  - Byte count += DATA_BYTES - (EOP ? empty : 0) per accepted beat.
  - Clear and increment in the same cycle: counter loads the increment value.
- in_packet:
  - Set on accepted SOP; cleared on accepted EOP.
  - SOP&&EOP in one beat leaves it 0.
- protocol_error: set on an accepted SOP while in_packet, or an accepted non-SOP beat while !in_packet.
  - The beat is still forwarded unchanged.
  - A W1C in the same cycle as a new error leaves it set.
- csr_waitrequest:
  - Asserted during reset.
  - Asserted for a write to addr 0 while in_packet, pipeline_busy, or an SOP is being accepted this cycle. Mode therefore never changes mid-packet.
  - Never asserted for reads or for other addresses.
- Reads: csr_readdatavalid pulses 1 cycle after csr_read, with csr_readdata registered the same cycle.
- Reset mid-packet: pipeline contents are discarded, no output beat is emitted, and all state returns to reset values.

Decomposition:
- endian_swapper_pkg:
  - CSR address constants (CSR_CTRL, CSR_PKT_CNT, CSR_BYTE_CNT, CSR_STATUS).
  - Status bit indices.
  - Parametrised swap function: data, mode -> data; implemented with a loop, no hardwired width.
- Sub-module stream_skid_buffer: generic payload-width two-register ready/valid buffer. The top level packs data/empty/SOP/EOP into the payload.

Test Plan (DATA_BYTES=8):
- Mode writes, one 1-beat packet each:
  - Write addr0=3, send 0x0001020304050607 -> out 0x0706050403020100 after 1 cycle.
  - Mode 1 -> 0x0100030205040706.
  - Mode 2 -> 0x0302010007060504.
  - Mode 0 -> unchanged.
- Backpressure: 4-beat packet, out_ready toggled 1,0,0,1,... -> stream_in_ready low the cycle after the skid fills; all 4 beats appear in order with no gaps while ready=1.
- Counters: 3 packets of 2 beats, last beat empty=3 -> addr1 reads 3, addr2 reads 39. Write addr1 in the same cycle as an SOP accept -> reads 1.
- Mid-packet write: write addr0=2 while in_packet -> waitrequest high until EOP accepted and pipeline drained; mode takes effect on the next packet only.
- Protocol error: two SOPs without EOP -> addr3 bit1=1. Write addr3=0x2 -> bit1=0. Both beats forwarded.
- Reset mid-packet: assert reset with 2 beats buffered -> stream_out_valid=0 next cycle, counters 0, mode 0, in_ready=1 after deassertion.
